alu_bool_seq: RTL and testbench

Parametrised, multi-cycle successor to the Beta ALU boolean unit. It computes y[i] = bfn[{b[i],a[i]}] for every bit over a WIDTH-bit word. It processes the word SLICE bits per cycle through a narrow datapath and also produces a zero flag. Valid/ready handshakes on input and output let it sit behind the ALU operand registers and ahead of the writeback mux, in area-constrained builds.

---
 rtl/alu_bool_pkg.sv | 19 +
 rtl/alu_bool_slice.sv | 21 ++
 rtl/alu_bool_seq.sv | 117 +++++++++++
 tb/tb_alu_bool_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bool_pkg.sv
// Shared types and function-code constants for the sliced boolean ALU.
// The bfn encodings are the truth tables indexed by {b_bit, a_bit}.
package alu_bool_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BFN_AND  = 4'b1000;
  localparam logic [3:0] BFN_OR   = 4'b1110;
  localparam logic [3:0] BFN_XOR  = 4'b0110;
  localparam logic [3:0] BFN_A    = 4'b1010;
  localparam logic [3:0] BFN_B    = 4'b1100;
  localparam logic [3:0] BFN_ZERO = 4'b0000;
  localparam logic [3:0] BFN_ONES = 4'b1111;

endpackage

// File: rtl/alu_bool_slice.sv
// Combinational truth-table evaluator for one SLICE-bit chunk of the word.
// Each result bit selects bfn[{b_bit, a_bit}].
module alu_bool_slice
  import alu_bool_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [3:0]       bfn,
  output logic [SLICE-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < SLICE; i++) begin
      y[i] = bfn[{b[i], a[i]}];
    end
  end

endmodule

// File: rtl/alu_bool_seq.sv
// Multi-cycle boolean unit: evaluates WIDTH bits SLICE at a time through one
// shared slice evaluator, with valid/ready on both sides and a zero flag.
//
// state | meaning
// IDLE  | ready for a new operation; y holds the previous result
// BUSY  | evaluating slice r_idx of the latched operands
// DONE  | result valid, waiting for out_ready
module alu_bool_seq
  import alu_bool_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       bfn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_cfg
      $error("alu_bool_seq: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_bfn;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_y;
  logic             r_zero_acc;
  logic             r_zero;
  logic             r_out_valid;

  logic             w_accept;
  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_y_sl;
  logic             w_sl_zero;

  // in_ready drops combinationally with reset so nothing is accepted under reset
  assign in_ready  = (r_state == IDLE) && !reset;
  assign w_accept  = in_valid && in_ready;
  assign w_a_sl    = r_a[int'(r_idx)*SLICE +: SLICE];
  assign w_b_sl    = r_b[int'(r_idx)*SLICE +: SLICE];
  assign w_sl_zero = (w_y_sl == '0);

  alu_bool_slice #(.SLICE(SLICE)) u_slice (
    .a   (w_a_sl),
    .b   (w_b_sl),
    .bfn (r_bfn),
    .y   (w_y_sl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_bfn       <= '0;
      r_idx       <= '0;
      r_y         <= '0;
      r_zero_acc  <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a        <= a;
            r_b        <= b;
            r_bfn      <= bfn;
            r_y        <= '0;
            r_zero_acc <= 1'b1;
            r_idx      <= '0;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          r_y[int'(r_idx)*SLICE +: SLICE] <= w_y_sl;
          r_zero_acc <= r_zero_acc & w_sl_zero;
          if (r_idx == LAST_IDX) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_zero      <= r_zero_acc & w_sl_zero;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_bool_seq.sv
// Directed and table-driven checks for alu_bool_seq, plus two extra
// instances covering the single-slice and 64/16 configurations.
module tb_alu_bool_seq;
  import alu_bool_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance: 32/8
  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [31:0] a, b, y;
  logic [3:0]  bfn;

  alu_bool_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bfn(bfn), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero)
  );

  // single-slice instance: 32/32
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_zero;
  logic [31:0] s_a, s_b, s_y;
  logic [3:0]  s_bfn;

  alu_bool_seq #(.WIDTH(32), .SLICE(32)) dut_s32 (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .bfn(s_bfn), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .y(s_y), .zero(s_zero)
  );

  // wide instance: 64/16
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_zero;
  logic [63:0] w_a, w_b, w_y;
  logic [3:0]  w_bfn;

  alu_bool_seq #(.WIDTH(64), .SLICE(16)) dut_w64 (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .bfn(w_bfn), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .y(w_y), .zero(w_zero)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_bool(input logic [63:0] ra, input logic [63:0] rb,
                                           input logic [3:0] f);
    return (ra & rb & {64{f[3]}}) | (ra & ~rb & {64{f[1]}}) |
           (~ra & rb & {64{f[2]}}) | (~ra & ~rb & {64{f[0]}});
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  bfn;
    logic [31:0] y;
    logic        zero;
  } vec_t;

  // Full operation on the main instance; operands are scrambled after accept.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [3:0] tf,
                        input logic [31:0] ey, input logic ez, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, " in_ready idle"}, 64'(in_ready), 64'(1));
    a = ta; b = tb; bfn = tf; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0; a = ~ta; b = $urandom; bfn = ~tf;
    chk({nm, " in_ready busy"}, 64'(in_ready), 64'(0));
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(5));
    chk({nm, " y"}, 64'(y), 64'(ey));
    chk({nm, " zero"}, 64'(zero), 64'(ez));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " retire"}, 64'(out_valid), 64'(0));
  endtask

  task automatic run_s32(input logic [31:0] ta, input logic [31:0] tb, input logic [3:0] tf);
    int lat;
    logic [31:0] ey;
    ey = 32'(ref_bool(64'(ta), 64'(tb), tf));
    @(negedge clk);
    s_a = ta; s_b = tb; s_bfn = tf; s_in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    s_in_valid = 1'b0;
    while (!s_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("s32 latency", 64'(lat), 64'(2));
    chk("s32 y", 64'(s_y), 64'(ey));
    chk("s32 zero", 64'(s_zero), 64'(ey == 32'd0));
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
  endtask

  task automatic run_w64(input logic [63:0] ta, input logic [63:0] tb, input logic [3:0] tf);
    int lat;
    logic [63:0] ey;
    ey = ref_bool(ta, tb, tf);
    @(negedge clk);
    w_a = ta; w_b = tb; w_bfn = tf; w_in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    w_in_valid = 1'b0;
    while (!w_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("w64 latency", 64'(lat), 64'(5));
    chk("w64 y", w_y, ey);
    chk("w64 zero", 64'(w_zero), 64'(ey == 64'd0));
    w_out_ready = 1'b1;
    @(negedge clk);
    w_out_ready = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'hF0F000FF, 32'hFF000F0F, BFN_AND,  32'hF000000F, 1'b0};
    vecs[1] = '{32'hF0F000FF, 32'hFF000F0F, BFN_OR,   32'hFFF00FFF, 1'b0};
    vecs[2] = '{32'hF0F000FF, 32'hFF000F0F, BFN_XOR,  32'h0FF00FF0, 1'b0};
    vecs[3] = '{32'hF0F000FF, 32'hFF000F0F, BFN_ZERO, 32'h00000000, 1'b1};
    vecs[4] = '{32'hF0F000FF, 32'hFF000F0F, BFN_ONES, 32'hFFFFFFFF, 1'b0};
    vecs[5] = '{32'h12345678, 32'hEDCBA987, BFN_AND,  32'h00000000, 1'b1};
    vecs[6] = '{32'h00000100, 32'h00000000, BFN_A,    32'h00000100, 1'b0};
    vecs[7] = '{32'h00000000, 32'hA5000000, BFN_B,    32'hA5000000, 1'b0};
    vecs[8] = '{32'hF0F000FF, 32'hFF000F0F, 4'b0001,  32'h000FF000, 1'b0};

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bfn = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_bfn = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = '0; w_b = '0; w_bfn = '0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset y", 64'(y), 64'(0));
    chk("reset zero", 64'(zero), 64'(0));
    chk("reset in_ready", 64'(in_ready), 64'(0));
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bfn, vecs[i].y, vecs[i].zero,
             $sformatf("vec%0d", i));
    end

    // backpressure: hold DONE for 6 cycles while the input side churns
    @(negedge clk);
    a = 32'hF0F000FF; b = 32'hFF000F0F; bfn = BFN_XOR; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0]; a = $urandom; bfn = 4'(i);
      chk("bp y", 64'(y), 64'h0FF00FF0);
      chk("bp zero", 64'(zero), 64'(0));
      chk("bp in_ready", 64'(in_ready), 64'(0));
      chk("bp out_valid", 64'(out_valid), 64'(1));
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp release out_valid", 64'(out_valid), 64'(0));
    chk("bp release in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    chk("bp no phantom accept", 64'(in_ready), 64'(1));
    run_op(32'hF0F000FF, 32'hFF000F0F, BFN_OR, 32'hFFF00FFF, 1'b0, "after bp");

    // reset during the second BUSY cycle
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'h0; bfn = BFN_A; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset out_valid", 64'(out_valid), 64'(0));
    chk("midreset y", 64'(y), 64'(0));
    chk("midreset in_ready", 64'(in_ready), 64'(0));
    reset = 1'b0;
    #1;
    chk("midreset idle", 64'(in_ready), 64'(1));
    @(negedge clk);
    chk("midreset no result", 64'(out_valid), 64'(0));
    run_op(32'h12345678, 32'hEDCBA987, BFN_XOR, 32'hFFFFFFFF, 1'b0, "after reset");

    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra, rb;
      logic [3:0]  rf;
      logic [31:0] ey;
      ra = $urandom; rb = $urandom; rf = 4'($urandom_range(0, 15));
      ey = 32'(ref_bool(64'(ra), 64'(rb), rf));
      run_op(ra, rb, rf, ey, ey == 32'd0, $sformatf("rand%0d", i));
    end

    run_s32(32'hF0F000FF, 32'hFF000F0F, BFN_AND);
    run_s32(32'h12345678, 32'hEDCBA987, BFN_AND);
    for (int i = 0; i < 3; i++) run_s32($urandom, $urandom, 4'($urandom_range(0, 15)));

    run_w64(64'h0000000100000000, 64'h0, BFN_A);
    run_w64(64'hFFFF0000FFFF0000, 64'h0000FFFF0000FFFF, BFN_AND);
    for (int i = 0; i < 3; i++) begin
      run_w64({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
